// File: rtl/jtag_types_pkg.sv
// Shared JTAG types: TAP states, IR opcodes and the opcode legality check.
package jtag_types_pkg;

  localparam int unsigned DEFAULT_IR_WIDTH = 4;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam logic [3:0] EXTEST  = 4'b0000;
  localparam logic [3:0] IDCODE  = 4'b0001;
  localparam logic [3:0] SAMPLE  = 4'b0010;
  localparam logic [3:0] PRELOAD = 4'b0011;
  localparam logic [3:0] AHB     = 4'b0100;
  localparam logic [3:0] BYPASS  = 4'b1111;

  localparam logic [1:0] IR_CAPTURE_LSB = 2'b01;

  // Takes the opcode zero-extended to 32 bits so any IR_WIDTH can use it.
  function automatic logic is_valid_opcode(input logic [31:0] op);
    logic ok;
    ok = 1'b0;
    if (op == 32'(EXTEST) || op == 32'(IDCODE) || op == 32'(SAMPLE) ||
        op == 32'(PRELOAD) || op == 32'(AHB) || op == 32'(BYPASS))
      ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/ir_shift_counter.sv
// Saturating bit counter for IR shifts, cleared on capture.
module ir_shift_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MAX   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != WIDTH'(MAX))) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/instruction_register.sv
// JTAG instruction register: capture status, shift LSB first, latch on Update-IR.
module instruction_register
  import jtag_types_pkg::*;
#(
  parameter int unsigned IR_WIDTH = DEFAULT_IR_WIDTH
) (
  input  logic                TCK,
  input  logic                TRST,
  input  tap_state_t          tap_state,
  input  logic                TDI,
  output logic [IR_WIDTH-1:0] parallel_out,
  output logic                tdo,
  output logic                tdo_en,
  output logic                ir_len_error
);

  localparam int unsigned CNT_W   = $clog2(IR_WIDTH + 2);
  localparam int unsigned CNT_MAX = IR_WIDTH + 1;

  logic [IR_WIDTH-1:0] shift_reg;
  logic [IR_WIDTH-1:0] capture_val;
  logic [CNT_W-1:0]    shift_cnt;
  logic                in_capture;
  logic                in_shift;
  logic                len_ok;
  logic                op_ok;

  assign in_capture = (tap_state == CAPTURE_IR);
  assign in_shift   = (tap_state == SHIFT_IR);
  assign len_ok     = (shift_cnt == CNT_W'(IR_WIDTH));
  assign op_ok      = is_valid_opcode(32'(shift_reg));

  // Capture pattern reports the previous update's length error in bit 2.
  always_comb begin
    capture_val      = '0;
    capture_val[1:0] = IR_CAPTURE_LSB;
    capture_val[2]   = ir_len_error;
  end

  ir_shift_counter #(
    .WIDTH(CNT_W),
    .MAX  (CNT_MAX)
  ) u_cnt (
    .clk  (TCK),
    .rst_n(TRST),
    .clr  (in_capture),
    .en   (in_shift),
    .cnt  (shift_cnt)
  );

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      shift_reg <= IR_WIDTH'(IR_CAPTURE_LSB);
    end else if (in_capture) begin
      shift_reg <= capture_val;
    end else if (in_shift) begin
      shift_reg <= {TDI, shift_reg[IR_WIDTH-1:1]};
    end
  end

  // Wrong-length shifts and undefined opcodes both fall back to BYPASS.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      parallel_out <= IR_WIDTH'(IDCODE);
      ir_len_error <= 1'b0;
    end else begin
      case (tap_state)
        TEST_LOGIC_RESET: begin
          parallel_out <= IR_WIDTH'(IDCODE);
          ir_len_error <= 1'b0;
        end
        UPDATE_IR: begin
          ir_len_error <= !len_ok;
          parallel_out <= (len_ok && op_ok) ? shift_reg : IR_WIDTH'(BYPASS);
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else if (in_shift) begin
      tdo    <= shift_reg[0];
      tdo_en <= 1'b1;
    end else begin
      tdo_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_register.sv
// Directed bench for instruction_register with a bit-stream reference model.
module tb_instruction_register;
  import jtag_types_pkg::*;

  logic       TCK  = 1'b0;
  logic       TRST = 1'b1;
  logic       TDI  = 1'b0;
  tap_state_t tap_state = TEST_LOGIC_RESET;
  logic [3:0] parallel_out;
  logic       tdo;
  logic       tdo_en;
  logic       ir_len_error;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: every bit that has passed through the IR since the last capture/reset.
  bit         stream[$];
  int         m_cnt;
  logic [3:0] m_po;
  bit         m_err;
  bit         m_tdo;
  bit         m_en;
  logic [7:0] tdo_log;

  instruction_register #(.IR_WIDTH(4)) dut (
    .TCK         (TCK),
    .TRST        (TRST),
    .tap_state   (tap_state),
    .TDI         (TDI),
    .parallel_out(parallel_out),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .ir_len_error(ir_len_error)
  );

  always #5 TCK = ~TCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit valid_op(input logic [3:0] v);
    return v inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF};
  endfunction

  function automatic void m_reset();
    stream = '{1'b1, 1'b0, 1'b0, 1'b0};
    m_cnt  = 0;
    m_po   = 4'b0001;
    m_err  = 1'b0;
    m_tdo  = 1'b0;
    m_en   = 1'b0;
  endfunction

  function automatic void model_pos(input tap_state_t s, input bit d);
    logic [3:0] op;
    case (s)
      CAPTURE_IR: begin
        stream = '{1'b1, 1'b0, m_err, 1'b0};
        m_cnt  = 0;
      end
      SHIFT_IR: begin
        stream.push_back(d);
        m_cnt++;
      end
      UPDATE_IR: begin
        for (int i = 0; i < 4; i++) op[i] = stream[m_cnt + i];
        m_err = (m_cnt != 4);
        m_po  = (!m_err && valid_op(op)) ? op : 4'b1111;
      end
      TEST_LOGIC_RESET: begin
        m_po  = 4'b0001;
        m_err = 1'b0;
      end
      default: ;
    endcase
  endfunction

  // Starts and ends just after a posedge; state is held for one full TCK cycle.
  task automatic step(input tap_state_t s, input logic d);
    tap_state = s;
    TDI       = d;
    @(negedge TCK);
    #1;
    if (s == SHIFT_IR) begin
      m_tdo   = stream[m_cnt];
      m_en    = 1'b1;
      tdo_log = {tdo, tdo_log[7:1]};
    end else begin
      m_en = 1'b0;
    end
    chk("tdo", 32'(tdo), 32'(m_tdo));
    chk("tdo_en", 32'(tdo_en), 32'(m_en));
    @(posedge TCK);
    model_pos(s, d);
    #1;
    chk("parallel_out", 32'(parallel_out), 32'(m_po));
    chk("ir_len_error", 32'(ir_len_error), 32'(m_err));
  endtask

  task automatic shift_bits(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) step(SHIFT_IR, bits[i]);
  endtask

  task automatic go_capture();
    step(SELECT_DR, 1'b0);
    step(SELECT_IR, 1'b0);
    step(CAPTURE_IR, 1'b0);
    tdo_log = '0;
  endtask

  task automatic go_update();
    step(EXIT1_IR, 1'b0);
    step(UPDATE_IR, 1'b0);
  endtask

  initial begin
    m_reset();
    tdo_log = '0;
    #1 TRST = 1'b0;
    #1;
    chk("rst_po", 32'(parallel_out), 32'h1);
    chk("rst_err", 32'(ir_len_error), 32'h0);
    chk("rst_tdo", 32'(tdo), 32'h0);
    chk("rst_tdo_en", 32'(tdo_en), 32'h0);
    @(posedge TCK);
    #1 TRST = 1'b1;

    step(TEST_LOGIC_RESET, 1'b0);
    step(RUN_TEST_IDLE, 1'b0);

    // AHB: TDI 0,0,1,0 LSB first
    go_capture();
    shift_bits(8'b0000_0100, 4);
    chk("cap_tdo_seq", 32'(tdo_log[7:4]), 32'b0001);
    go_update();
    chk("ahb_po", 32'(parallel_out), 32'b0100);
    chk("ahb_err", 32'(ir_len_error), 32'h0);

    // Short shift
    go_capture();
    shift_bits(8'b0000_0111, 3);
    go_update();
    chk("short_po", 32'(parallel_out), 32'b1111);
    chk("short_err", 32'(ir_len_error), 32'h1);

    // Capture reflects the error; then undefined opcode 1010
    go_capture();
    shift_bits(8'b0000_1010, 4);
    chk("err_cap_tdo_seq", 32'(tdo_log[7:4]), 32'b0101);
    go_update();
    chk("undef_po", 32'(parallel_out), 32'b1111);
    chk("undef_err", 32'(ir_len_error), 32'h0);

    // EXTEST with a pause in the middle
    go_capture();
    shift_bits(8'b0000_0000, 2);
    step(EXIT1_IR, 1'b1);
    step(PAUSE_IR, 1'b1);
    step(PAUSE_IR, 1'b1);
    step(EXIT2_IR, 1'b1);
    shift_bits(8'b0000_0000, 2);
    go_update();
    chk("pause_po", 32'(parallel_out), 32'b0000);
    chk("pause_err", 32'(ir_len_error), 32'h0);
    step(TEST_LOGIC_RESET, 1'b0);
    chk("tlr_po", 32'(parallel_out), 32'b0001);
    step(RUN_TEST_IDLE, 1'b0);

    // Long shift
    go_capture();
    shift_bits(8'b0011_1111, 6);
    go_update();
    chk("long_po", 32'(parallel_out), 32'b1111);
    chk("long_err", 32'(ir_len_error), 32'h1);
    chk("long_cnt_sat", 32'(dut.shift_cnt), 32'd5);

    // Async reset mid-shift, no clock edge needed
    go_capture();
    shift_bits(8'b0000_0011, 2);
    #1 TRST = 1'b0;
    #1;
    chk("midrst_po", 32'(parallel_out), 32'b0001);
    chk("midrst_tdo_en", 32'(tdo_en), 32'h0);
    chk("midrst_err", 32'(ir_len_error), 32'h0);
    chk("midrst_tdo", 32'(tdo), 32'h0);
    m_reset();
    @(posedge TCK);
    #1 TRST = 1'b1;

    // Update with no capture after reset sees a zero count
    step(UPDATE_IR, 1'b0);
    chk("postrst_po", 32'(parallel_out), 32'b1111);
    chk("postrst_err", 32'(ir_len_error), 32'h1);
    step(RUN_TEST_IDLE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
